instruction_fetch_unit: RTL and testbench

//  Requester side of the instruction memory read port. Holds the program counter and drives
//  the word address into instruction_memory. Absorbs the 1-cycle synchronous read latency and

---
 rtl/instruction_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, drives instruction memory, hides its 1-cycle read latency
// and hands {instruction, pc} to decode through a 2-entry skid buffer with redirect/flush.
module instruction_fetch_unit #(
  parameter int DATA_LENGTH = 32,
  parameter int MEM_LENGTH  = 32,
  parameter int RESET_PC    = 0,
  localparam int AW = $clog2(MEM_LENGTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [AW-1:0]          address,
  input  logic [DATA_LENGTH-1:0] return_data,
  input  logic                   redirect_valid,
  input  logic [AW-1:0]          redirect_address,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [DATA_LENGTH-1:0] instr_data,
  output logic [AW-1:0]          instr_pc
);

  typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;

  localparam logic [AW-1:0] LAST_ADDR   = AW'(MEM_LENGTH - 1);
  localparam logic [AW-1:0] START_ADDR  = AW'(RESET_PC);
  localparam logic [AW:0]   MEM_LEN_EXT = (AW+1)'(MEM_LENGTH);

  state_t                 state;
  logic                   in_flight;
  logic [AW-1:0]          in_flight_pc;
  logic                   head_valid, tail_valid;
  logic [DATA_LENGTH-1:0] head_data, tail_data;
  logic [AW-1:0]          head_pc, tail_pc;

  logic                   pop;
  logic [1:0]             occupancy;
  logic [1:0]             slots_used;
  logic                   can_issue;
  logic [AW-1:0]          next_pc;
  logic [AW-1:0]          redirect_target;

  logic                   nxt_head_valid, nxt_tail_valid;
  logic [DATA_LENGTH-1:0] nxt_head_data, nxt_tail_data;
  logic [AW-1:0]          nxt_head_pc, nxt_tail_pc;

  assign instr_valid = head_valid;
  assign instr_data  = head_data;
  assign instr_pc    = head_pc;

  // Issue only when the word we launch now is guaranteed a buffer slot on arrival.
  assign pop        = head_valid & instr_ready;
  assign occupancy  = {1'b0, head_valid} + {1'b0, tail_valid};
  assign slots_used = occupancy - {1'b0, pop} + {1'b0, in_flight};
  assign can_issue  = slots_used < 2'd2;

  assign next_pc         = (address == LAST_ADDR) ? '0 : address + 1'b1;
  assign redirect_target = ({1'b0, redirect_address} >= MEM_LEN_EXT)
                           ? redirect_address - MEM_LEN_EXT[AW-1:0]
                           : redirect_address;

  always_comb begin
    nxt_head_valid = head_valid;
    nxt_head_data  = head_data;
    nxt_head_pc    = head_pc;
    nxt_tail_valid = tail_valid;
    nxt_tail_data  = tail_data;
    nxt_tail_pc    = tail_pc;
    if (pop) begin
      nxt_head_valid = tail_valid;
      nxt_head_data  = tail_data;
      nxt_head_pc    = tail_pc;
      nxt_tail_valid = 1'b0;
    end
    if (in_flight) begin
      if (!nxt_head_valid) begin
        nxt_head_valid = 1'b1;
        nxt_head_data  = return_data;
        nxt_head_pc    = in_flight_pc;
      end else begin
        nxt_tail_valid = 1'b1;
        nxt_tail_data  = return_data;
        nxt_tail_pc    = in_flight_pc;
      end
    end
  end

  // A redirect wins over everything: drop the buffer and the word returning next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      address      <= START_ADDR;
      in_flight    <= 1'b0;
      in_flight_pc <= '0;
      head_valid   <= 1'b0;
      head_data    <= '0;
      head_pc      <= '0;
      tail_valid   <= 1'b0;
      tail_data    <= '0;
      tail_pc      <= '0;
    end else if (redirect_valid) begin
      state      <= FLUSH;
      address    <= redirect_target;
      in_flight  <= 1'b0;
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
    end else begin
      head_valid <= nxt_head_valid;
      head_data  <= nxt_head_data;
      head_pc    <= nxt_head_pc;
      tail_valid <= nxt_tail_valid;
      tail_data  <= nxt_tail_data;
      tail_pc    <= nxt_tail_pc;
      case (state)
        BOOT, FLUSH: begin
          in_flight    <= 1'b1;
          in_flight_pc <= address;
          address      <= next_pc;
          state        <= FETCH;
        end
        default: begin
          in_flight <= can_issue;
          if (can_issue) begin
            in_flight_pc <= address;
            address      <= next_pc;
          end
        end
      endcase
    end
  end

  redirect_in_range: assert property (@(posedge clk) disable iff (rst)
    redirect_valid |-> ({1'b0, redirect_address} < MEM_LEN_EXT));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle table for the directed scenarios, then a
// random run checked against a stream-level model of the fetch behaviour.
module tb_instruction_fetch_unit;

  localparam int DW = 32;
  localparam int ML = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic [AW-1:0] address;
  logic [DW-1:0] return_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_address;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;

  logic [DW-1:0] mem [ML];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int rdy;
    int redir;
    int tgt;
    int ev;
    int epc;
    int eaddr;
  } vec_t;

  vec_t vecs[$];

  instruction_fetch_unit #(.DATA_LENGTH(DW), .MEM_LENGTH(ML), .RESET_PC(0)) dut (
    .clk              (clk),
    .rst              (rst),
    .address          (address),
    .return_data      (return_data),
    .redirect_valid   (redirect_valid),
    .redirect_address (redirect_address),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_data       (instr_data),
    .instr_pc         (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory: address in cycle N, data during N+1.
  always @(posedge clk) return_data <= mem[address];

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int rdy, input int redir, input int tgt);
    instr_ready      = rdy[0];
    redirect_valid   = redir[0];
    redirect_address = tgt[AW-1:0];
  endtask

  // Leaves time at the release instant, i.e. inside the first cycle after reset.
  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkInstr(input string tag, input int pc);
    checkOutput({tag, "_valid"}, int'(instr_valid), 1);
    checkOutput({tag, "_pc"}, int'(instr_pc), pc);
    checkOutput({tag, "_data"}, int'(instr_data), int'(mem[pc]));
  endtask

  initial begin
    int exp_next;
    int cd;
    int rdy, redir, tgt;

    for (int i = 0; i < ML; i++) mem[i] = DW'(i + 100);

    // Boot, backpressure at pc 4, redirect while pc 7 handshakes, back-to-back redirects.
    vecs.push_back('{1, 0, 0,  0, -1,  0});
    vecs.push_back('{1, 0, 0,  0, -1, -1});
    vecs.push_back('{1, 0, 0,  1,  0, -1});
    vecs.push_back('{1, 0, 0,  1,  1, -1});
    vecs.push_back('{1, 0, 0,  1,  2, -1});
    vecs.push_back('{1, 0, 0,  1,  3, -1});
    vecs.push_back('{0, 0, 0,  1,  4, -1});
    vecs.push_back('{0, 0, 0,  1,  4, -1});
    vecs.push_back('{0, 0, 0,  1,  4,  6});
    vecs.push_back('{0, 0, 0,  1,  4,  6});
    vecs.push_back('{0, 0, 0,  1,  4,  6});
    vecs.push_back('{1, 0, 0,  1,  4,  6});
    vecs.push_back('{1, 0, 0,  1,  5,  7});
    vecs.push_back('{1, 0, 0,  1,  6, -1});
    vecs.push_back('{1, 1, 20, 1,  7, -1});
    vecs.push_back('{1, 0, 0,  0, -1, 20});
    vecs.push_back('{1, 0, 0,  0, -1, 21});
    vecs.push_back('{1, 0, 0,  1, 20, -1});
    vecs.push_back('{1, 1, 10, 1, 21, -1});
    vecs.push_back('{1, 1, 3,  0, -1, 10});
    vecs.push_back('{1, 0, 0,  0, -1,  3});
    vecs.push_back('{1, 0, 0,  0, -1, -1});
    vecs.push_back('{1, 0, 0,  1,  3, -1});
    vecs.push_back('{1, 0, 0,  1,  4, -1});

    doReset();
    checkOutput("rst_pc", int'(instr_pc), 0);
    checkOutput("rst_data", int'(instr_data), 0);
    foreach (vecs[i]) begin
      if (vecs[i].ev != 0) checkInstr($sformatf("vec%0d", i + 1), vecs[i].epc);
      else checkOutput($sformatf("vec%0d_valid", i + 1), int'(instr_valid), 0);
      if (vecs[i].eaddr >= 0)
        checkOutput($sformatf("vec%0d_addr", i + 1), int'(address), vecs[i].eaddr);
      applyStimulus(vecs[i].rdy, vecs[i].redir, vecs[i].tgt);
      @(negedge clk);
    end

    // Address wrap at MEM_LENGTH-1 with continuous back-to-back delivery.
    doReset();
    for (int k = 1; k <= 44; k++) begin
      if (k < 3) checkOutput($sformatf("wrap%0d_valid", k), int'(instr_valid), 0);
      else checkInstr($sformatf("wrap%0d", k), (k - 3) % ML);
      applyStimulus(1, 0, 0);
      @(negedge clk);
    end

    // Asynchronous reset with the skid buffer full, then a clean restart at RESET_PC.
    applyStimulus(0, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("prerst_valid", int'(instr_valid), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", int'(instr_valid), 0);
    checkOutput("async_rst_addr", int'(address), 0);
    checkOutput("async_rst_pc", int'(instr_pc), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k < 3) checkOutput($sformatf("restart%0d_valid", k), int'(instr_valid), 0);
      else checkInstr($sformatf("restart%0d", k), k - 3);
      applyStimulus(1, 0, 0);
      @(negedge clk);
    end

    // Random ready/redirect traffic. Model: instructions leave in PC order starting at the
    // last target; output is invalid for exactly two cycles after a redirect (or boot)
    // and valid from then on until the next redirect.
    for (int i = 0; i < ML; i++) mem[i] = $urandom();
    doReset();
    exp_next = 0;
    cd = 3;
    for (int k = 1; k <= 3000; k++) begin
      if (cd != 0) begin
        cd--;
        checkOutput("rnd_gap_valid", int'(instr_valid), (cd != 0) ? 0 : 1);
      end else begin
        checkOutput("rnd_stream_valid", int'(instr_valid), 1);
      end
      if (instr_valid) begin
        checkOutput("rnd_pc", int'(instr_pc), exp_next);
        checkOutput("rnd_data", int'(instr_data), int'(mem[exp_next]));
      end
      rdy   = ($urandom_range(9) < 7) ? 1 : 0;
      redir = ($urandom_range(19) == 0) ? 1 : 0;
      tgt   = $urandom_range(ML - 1);
      applyStimulus(rdy, redir, tgt);
      if (instr_valid && rdy != 0) exp_next = (exp_next + 1) % ML;
      if (redir != 0) begin
        exp_next = tgt;
        cd = 3;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
